// File: rtl/gate_resp_checker.sv
// Self-checking response monitor for a two-input logic gate: it scores the observed
// output against a selected boolean function and records coverage and the first failure.
module gate_resp_checker #(
   parameter int CNT_W   = 8,
   parameter int LATENCY = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [2:0]       op,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err,
   output logic [CNT_W-1:0] check_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       cov,
   output logic [2:0]       first_err
);

   typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [1:0]       FILL_LAST = 2'(LATENCY - 1);

   state_t           state;
   logic [2:0]       op_q;
   logic [1:0]       fill_cnt;
   logic [1:0]       ab_d;
   logic             exp_bit;
   logic             mismatch;
   logic [CNT_W-1:0] chk_nxt;
   logic [CNT_W-1:0] errc_nxt;
   logic [3:0]       cov_nxt;
   logic             pass_nxt;

   // Align the inputs with the output they produced LATENCY cycles later.
   generate
      if (LATENCY == 0) begin : g_nodly
         assign ab_d = {in_a, in_b};
      end else begin : g_dly
         logic [LATENCY-1:0][1:0] dly;

         // NOTE: the delay line is cleared on reset and at session start so no
         // stale input pair from an earlier session can ever be compared.
         always_ff @(posedge clk) begin
            if (rst || ((state == IDLE || state == DONE) && start)) begin
               dly <= '0;
            end else if (state == FILL || state == CHECK) begin
               dly[0] <= {in_a, in_b};
               for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
            end
         end

         assign ab_d = dly[LATENCY-1];
      end
   endgenerate

   // NOTE: every variable gets a default at the top so no latch is inferred.
   always_comb begin
      exp_bit = 1'b0;
      case (op_q)
         3'd0:    exp_bit =   ab_d[1] & ab_d[0];
         3'd1:    exp_bit =   ab_d[1] | ab_d[0];
         3'd2:    exp_bit =   ab_d[1] ^ ab_d[0];
         3'd3:    exp_bit = ~(ab_d[1] & ab_d[0]);
         3'd4:    exp_bit = ~(ab_d[1] | ab_d[0]);
         3'd5:    exp_bit = ~(ab_d[1] ^ ab_d[0]);
         default: exp_bit = 1'b0;
      endcase
      mismatch = (out != exp_bit);
      chk_nxt  = (check_cnt == CNT_MAX) ? check_cnt : check_cnt + 1'b1;
      errc_nxt = (mismatch && err_cnt != CNT_MAX) ? err_cnt + 1'b1 : err_cnt;
      cov_nxt  = cov | (4'b0001 << ab_d);
      pass_nxt = (errc_nxt == '0) && (cov_nxt == 4'hF) && (chk_nxt != '0);
   end

   // NOTE: all state uses non-blocking assignments; the early default for err
   // is overridden later in the same block, giving a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         fill_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err       <= 1'b0;
         check_cnt <= '0;
         err_cnt   <= '0;
         cov       <= '0;
         first_err <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  op_q      <= op;
                  fill_cnt  <= '0;
                  check_cnt <= '0;
                  err_cnt   <= '0;
                  cov       <= '0;
                  first_err <= '0;
                  pass      <= 1'b0;
                  if (op > 3'd5) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (LATENCY == 0) begin
                     state <= CHECK;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end else begin
                     state <= FILL;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end

            FILL: begin
               if (stop) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= 1'b0;
               end else if (fill_cnt == FILL_LAST) begin
                  state <= CHECK;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end

            CHECK: begin
               check_cnt <= chk_nxt;
               err_cnt   <= errc_nxt;
               cov       <= cov_nxt;
               err       <= mismatch;
               if (mismatch && err_cnt == '0) first_err <= {ab_d, out};
               if (stop) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= pass_nxt;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
